// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Initiator side of a LEGv8 ALU interface. It accepts one request (ALUOp,
// Opcode and two operands) and decodes it to a 4-bit ALU control code. It
// drives the ALU operand buses, waits SETTLE cycles and captures the ALU
// result and zero flag. The captured values are returned over a valid/ready
// response channel.
//
// Parameters: N (operand/result width), SETTLE (accept-to-sample cycles, >=1)
// Ports:
//   CLK, Reset_L            clock (rising edge), async active-low reset
//   ReqValid/ReqReady       request handshake (ReqReady high only when idle)
//   ALUOp, Opcode           request decode fields
//   OpA, OpB                request operands
//   AluCtrl, AluA, AluB     registered drive to the combinational ALU
//   AluW, AluZero           ALU result and zero flag
//   RespValid/RespReady     response handshake
//   Result, Zero, Illegal   captured response payload
// Optional feature macro ALU_SEQ_FLAGS_EN adds Negative and Overflow outputs,
// which are captured together with Result.

module alu_op_sequencer #(
    parameter int unsigned N      = 64,
    parameter int unsigned SETTLE = 3
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [1:0]   ALUOp,
    input  logic [10:0]  Opcode,
    input  logic [N-1:0] OpA,
    input  logic [N-1:0] OpB,
    output logic [3:0]   AluCtrl,
    output logic [N-1:0] AluA,
    output logic [N-1:0] AluB,
    input  logic [N-1:0] AluW,
    input  logic         AluZero,
    output logic         RespValid,
    input  logic         RespReady,
    output logic [N-1:0] Result,
    output logic         Zero,
`ifdef ALU_SEQ_FLAGS_EN
    output logic         Negative,
    output logic         Overflow,
`endif
    output logic         Illegal
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [3:0] CTRL_AND   = 4'b0000;
    localparam logic [3:0] CTRL_OR    = 4'b0001;
    localparam logic [3:0] CTRL_ADD   = 4'b0010;
    localparam logic [3:0] CTRL_SUB   = 4'b0110;
    localparam logic [3:0] CTRL_PASSB = 4'b0111;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [3:0]    dec_ctrl;
    logic          dec_legal;
    logic          accept;
    logic          capture;

    // Request decode to ALU control code
    always_comb begin
        dec_ctrl  = CTRL_AND;
        dec_legal = 1'b1;
        case (ALUOp)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_PASSB;
            2'b10: begin
                case (Opcode)
                    OPC_ADD: dec_ctrl = CTRL_ADD;
                    OPC_SUB: dec_ctrl = CTRL_SUB;
                    OPC_AND: dec_ctrl = CTRL_AND;
                    OPC_ORR: dec_ctrl = CTRL_OR;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ReqValid && ReqReady) begin
                    accept     = 1'b1;
                    state_next = dec_legal ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RespValid && RespReady) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ReqReady  <= 1'b1;
            RespValid <= 1'b0;
        end else begin
            ReqReady  <= (state_next == ST_IDLE);
            RespValid <= (state_next == ST_RESP);
        end
    end

    // Settle counter: reaches zero on the cycle whose edge samples the ALU
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cnt <= '0;
        end else if (accept && dec_legal) begin
            cnt <= CW'(SETTLE - 1);
        end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // ALU drive: only legal requests update it, otherwise the last op is held
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            AluCtrl <= CTRL_AND;
            AluA    <= '0;
            AluB    <= '0;
        end else if (accept && dec_legal) begin
            AluCtrl <= dec_ctrl;
            AluA    <= OpA;
            AluB    <= OpB;
        end
    end

    // Response payload
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            Result  <= '0;
            Zero    <= 1'b0;
            Illegal <= 1'b0;
        end else if (accept && !dec_legal) begin
            Result  <= '0;
            Zero    <= 1'b0;
            Illegal <= 1'b1;
        end else if (capture) begin
            Result  <= AluW;
            Zero    <= AluZero;
            Illegal <= 1'b0;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic ovf_c;

    // Signed overflow judged from operand and result signs
    always_comb begin
        ovf_c = 1'b0;
        if (AluCtrl == CTRL_ADD) begin
            ovf_c = (AluA[N-1] == AluB[N-1]) && (AluW[N-1] != AluA[N-1]);
        end else if (AluCtrl == CTRL_SUB) begin
            ovf_c = (AluA[N-1] != AluB[N-1]) && (AluW[N-1] != AluA[N-1]);
        end
    end

    // Flags captured alongside Result
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            Negative <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept && !dec_legal) begin
            Negative <= 1'b0;
            Overflow <= 1'b0;
        end else if (capture) begin
            Negative <= AluW[N-1];
            Overflow <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer (N=64, SETTLE=3). The ALU is
// modelled combinationally here. Expected responses come from a reference
// model that works from the instruction-level meaning of each request.
// Define ALU_SEQ_FLAGS_EN to build and check the Negative/Overflow outputs.

module tb_alu_op_sequencer;

    localparam int unsigned N      = 64;
    localparam int unsigned SETTLE = 3;

    logic         CLK;
    logic         Reset_L;
    logic         ReqValid;
    logic         ReqReady;
    logic [1:0]   ALUOp;
    logic [10:0]  Opcode;
    logic [N-1:0] OpA;
    logic [N-1:0] OpB;
    logic [3:0]   AluCtrl;
    logic [N-1:0] AluA;
    logic [N-1:0] AluB;
    logic [N-1:0] AluW;
    logic         AluZero;
    logic         RespValid;
    logic         RespReady;
    logic [N-1:0] Result;
    logic         Zero;
    logic         Illegal;
`ifdef ALU_SEQ_FLAGS_EN
    logic         Negative;
    logic         Overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what the ALU drive should currently hold
    logic [3:0]   prev_ctrl;
    logic [N-1:0] prev_a;
    logic [N-1:0] prev_b;

    alu_op_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ALUOp     (ALUOp),
        .Opcode    (Opcode),
        .OpA       (OpA),
        .OpB       (OpB),
        .AluCtrl   (AluCtrl),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluW      (AluW),
        .AluZero   (AluZero),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .Result    (Result),
        .Zero      (Zero),
`ifdef ALU_SEQ_FLAGS_EN
        .Negative  (Negative),
        .Overflow  (Overflow),
`endif
        .Illegal   (Illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Combinational ALU
    always_comb begin
        case (AluCtrl)
            4'b0000: AluW = AluA & AluB;
            4'b0001: AluW = AluA | AluB;
            4'b0010: AluW = AluA + AluB;
            4'b0110: AluW = AluA - AluB;
            4'b0111: AluW = AluB;
            default: AluW = '0;
        endcase
        AluZero = (AluW == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: what the request means, not how it is built
    task automatic model(input logic [1:0] op, input logic [10:0] opc,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic legal, output logic [3:0] ctrl,
                         output logic [63:0] res, output logic ovf);
        logic signed [64:0] wide;
        legal = 1'b1;
        ctrl  = 4'b0000;
        res   = '0;
        ovf   = 1'b0;
        wide  = '0;
        if (op == 2'b00 || (op == 2'b10 && opc == 11'b10001011000)) begin
            ctrl = 4'b0010;
            res  = a + b;
            wide = $signed({a[63], a}) + $signed({b[63], b});
            ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
        end else if (op == 2'b01) begin
            ctrl = 4'b0111;
            res  = b;
        end else if (op == 2'b10 && opc == 11'b11001011000) begin
            ctrl = 4'b0110;
            res  = a - b;
            wide = $signed({a[63], a}) - $signed({b[63], b});
            ovf  = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
        end else if (op == 2'b10 && opc == 11'b10001010000) begin
            ctrl = 4'b0000;
            res  = a & b;
        end else if (op == 2'b10 && opc == 11'b10101010000) begin
            ctrl = 4'b0001;
            res  = a | b;
        end else begin
            legal = 1'b0;
        end
    endtask

    // One full transaction, entered and left at a falling edge
    task automatic run_op(input logic [1:0] op, input logic [10:0] opc,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic        legal;
        logic [3:0]  ctrl;
        logic [63:0] er;
        logic        ovf;
        int          k;
        model(op, opc, a, b, legal, ctrl, er, ovf);
        chk("req_ready_idle", 64'(ReqReady), 64'(1));
        ReqValid = 1'b1;
        ALUOp    = op;
        Opcode   = opc;
        OpA      = a;
        OpB      = b;
        @(posedge CLK);
        @(negedge CLK);
        // Scramble request inputs: the ALU drive must not follow them
        ReqValid = 1'b0;
        ALUOp    = 2'($urandom);
        Opcode   = 11'($urandom);
        OpA      = {$urandom, $urandom};
        OpB      = {$urandom, $urandom};
        if (legal) begin
            prev_ctrl = ctrl;
            prev_a    = a;
            prev_b    = b;
        end
        k = 0;
        while (RespValid !== 1'b1 && k < 20) begin
            chk("wait_req_ready", 64'(ReqReady), 64'(0));
            chk("wait_alu_ctrl", 64'(AluCtrl), 64'(prev_ctrl));
            chk("wait_alu_a", AluA, prev_a);
            chk("wait_alu_b", AluB, prev_b);
            @(posedge CLK);
            @(negedge CLK);
            k++;
        end
        chk("resp_valid", 64'(RespValid), 64'(1));
        chk("latency", 64'(k), legal ? 64'(SETTLE) : 64'(0));
        chk("result", Result, er);
        chk("zero", 64'(Zero), 64'(legal && er == '0));
        chk("illegal", 64'(Illegal), 64'(!legal));
        chk("resp_alu_ctrl", 64'(AluCtrl), 64'(prev_ctrl));
`ifdef ALU_SEQ_FLAGS_EN
        chk("negative", 64'(Negative), 64'(legal && er[63]));
        chk("overflow", 64'(Overflow), 64'(legal && ovf));
`endif
        // Consumer stalls; a stray request must be ignored
        RespReady = 1'b0;
        for (int h = 0; h < hold; h++) begin
            ReqValid = 1'b1;
            OpA      = {$urandom, $urandom};
            @(posedge CLK);
            @(negedge CLK);
            chk("hold_resp_valid", 64'(RespValid), 64'(1));
            chk("hold_req_ready", 64'(ReqReady), 64'(0));
            chk("hold_result", Result, er);
            chk("hold_zero", 64'(Zero), 64'(legal && er == '0));
            chk("hold_alu_a", AluA, prev_a);
        end
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RespReady = 1'b0;
        chk("done_resp_valid", 64'(RespValid), 64'(0));
        chk("done_req_ready", 64'(ReqReady), 64'(1));
        chk("done_result", Result, er);
    endtask

    // Reset asserted while a transaction is in flight
    task automatic reset_in_flight(input logic [1:0] op, input logic [10:0] opc, input int cycles);
        ReqValid = 1'b1;
        ALUOp    = op;
        Opcode   = opc;
        OpA      = {$urandom, $urandom};
        OpB      = {$urandom, $urandom};
        @(posedge CLK);
        @(negedge CLK);
        ReqValid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        Reset_L = 1'b0;
        #1;
        chk("rst_req_ready", 64'(ReqReady), 64'(1));
        chk("rst_resp_valid", 64'(RespValid), 64'(0));
        chk("rst_alu_ctrl", 64'(AluCtrl), 64'(0));
        chk("rst_alu_a", AluA, 64'(0));
        chk("rst_result", Result, 64'(0));
        chk("rst_illegal", 64'(Illegal), 64'(0));
        prev_ctrl = 4'b0000;
        prev_a    = '0;
        prev_b    = '0;
        @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        Reset_L   = 1'b0;
        ReqValid  = 1'b0;
        RespReady = 1'b0;
        ALUOp     = 2'b00;
        Opcode    = '0;
        OpA       = '0;
        OpB       = '0;
        prev_ctrl = 4'b0000;
        prev_a    = '0;
        prev_b    = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_req_ready", 64'(ReqReady), 64'(1));
        chk("reset_resp_valid", 64'(RespValid), 64'(0));
        chk("reset_alu_ctrl", 64'(AluCtrl), 64'(0));
        chk("reset_alu_b", AluB, 64'(0));
        chk("reset_result", Result, 64'(0));
        chk("reset_zero", 64'(Zero), 64'(0));
        chk("reset_illegal", 64'(Illegal), 64'(0));
        Reset_L = 1'b1;
        @(negedge CLK);

        run_op(2'b10, 11'b10001011000, 64'd5, -64'sd7, 0);
        chk("dir_add_result", Result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("dir_add_ctrl", 64'(AluCtrl), 64'(4'b0010));
        run_op(2'b10, 11'b11001011000, 64'h1234, 64'h1234, 1);
        chk("dir_sub_zero", 64'(Zero), 64'(1));
        run_op(2'b01, 11'b0, {$urandom, $urandom}, 64'd0, 0);
        chk("dir_passb_zero", 64'(Zero), 64'(1));
        run_op(2'b00, 11'b0, 64'd8, 64'd16, 0);
        chk("dir_ldst_result", Result, 64'd24);
        run_op(2'b10, 11'b11111111111, 64'd1, 64'd2, 0);
        chk("dir_illegal_ctrl", 64'(AluCtrl), 64'(4'b0010));
        run_op(2'b11, 11'b10001011000, 64'd3, 64'd4, 2);
        run_op(2'b10, 11'b10001010000, 64'hF0F0, 64'h0FF0, 5);
        run_op(2'b10, 11'b10101010000, 64'hF000, 64'h000F, 0);
        run_op(2'b10, 11'b10001011000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op(2'b10, 11'b11001011000, 64'h8000_0000_0000_0000, 64'd1, 0);

        reset_in_flight(2'b00, 11'b0, 1);
        reset_in_flight(2'b11, 11'b0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [10:0] opc;
            logic [63:0] a;
            logic [63:0] b;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: opc = 11'b10001011000;
                1: opc = 11'b11001011000;
                2: opc = 11'b10001010000;
                3: opc = 11'b10101010000;
                default: opc = 11'($urandom);
            endcase
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            run_op(op, opc, a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
